// File: rtl/mult_nxn_seq.sv
// ---------------------------------------------------------------------------
// mult_nxn_seq
//
// Time-multiplexed WIDTH x WIDTH multiplier built from two half-width
// (H = WIDTH/2) multipliers. Each operand is split into low and high halves.
// The four half-products are produced over two cycles and accumulated into
// a 2*WIDTH result. Optional per-transaction two's complement mode works on
// operand magnitudes and negates the final sum.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands and mode valid
//   in_ready     block can accept operands this cycle (from state/out_ready)
//   in_1         multiplicand, WIDTH bits
//   in_2         multiplier, WIDTH bits
//   signed_mode  1 = in_1/in_2 are two's complement (sampled at accept)
//   out_valid    prod holds a finished result
//   out_ready    downstream consumes prod
//   prod         registered product, 2*WIDTH bits
//
// Timing: accept edge E0 captures magnitudes, E1 accumulates the bL
// products, E2 adds the bH products and raises out_valid. Result stays
// stable until consumed. With out_ready held high a new accept can coincide
// with the consume edge, giving one result every 3 cycles.
// ---------------------------------------------------------------------------
module mult_nxn_seq #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_1,
  input  logic [WIDTH-1:0]   in_2,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  generate
    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("mult_nxn_seq: WIDTH must be even and at least 4");
    end
  endgenerate

  // Encoding kept identical to the legacy state constants.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Captured operand magnitudes and result sign.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_q;

  // Partial sum carried from LO into HI.
  logic [PW-1:0]    acc;

  // ------------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------------
  logic accept;

  always_comb begin
    in_ready = (state == IDLE) || ((state == OUT) && out_ready);
  end

  always_comb begin
    accept = in_valid && in_ready;
  end

  // ------------------------------------------------------------------------
  // Operand conditioning at accept
  // ------------------------------------------------------------------------
  logic             use_signed;
  logic [WIDTH-1:0] mag_1;
  logic [WIDTH-1:0] mag_2;
  logic             neg_in;

  always_comb begin
    use_signed = (SIGNED_EN != 0) && signed_mode;
  end

  // Two's complement negation in WIDTH bits: the most negative value maps to
  // 2^(WIDTH-1), which is exactly representable as an unsigned magnitude.
  always_comb begin
    mag_1 = in_1;
    mag_2 = in_2;
    if (use_signed && in_1[WIDTH-1]) begin
      mag_1 = '0 - in_1;
    end
    if (use_signed && in_2[WIDTH-1]) begin
      mag_2 = '0 - in_2;
    end
  end

  always_comb begin
    neg_in = use_signed && (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
  end

  // ------------------------------------------------------------------------
  // Half-width multipliers
  //
  // Both multipliers share the b-half selected by state: bL outside HI,
  // bH in HI. Multiplier 1 always takes aL, multiplier 2 always takes aH.
  // In IDLE/OUT the products are computed but unused.
  // ------------------------------------------------------------------------
  logic [H-1:0]     mul_b_sel;
  logic [WIDTH-1:0] mul1_p;
  logic [WIDTH-1:0] mul2_p;
  logic [PW-1:0]    mul1_w;
  logic [PW-1:0]    mul2_w;

  always_comb begin
    mul_b_sel = (state == HI) ? b_mag[WIDTH-1:H] : b_mag[H-1:0];
  end

  always_comb begin
    mul1_p = {{H{1'b0}}, a_mag[H-1:0]}     * {{H{1'b0}}, mul_b_sel};
    mul2_p = {{H{1'b0}}, a_mag[WIDTH-1:H]} * {{H{1'b0}}, mul_b_sel};
  end

  always_comb begin
    mul1_w = {{WIDTH{1'b0}}, mul1_p};
    mul2_w = {{WIDTH{1'b0}}, mul2_p};
  end

  // ------------------------------------------------------------------------
  // Accumulation
  // ------------------------------------------------------------------------
  logic [PW-1:0] acc_lo;
  logic [PW-1:0] sum_hi;
  logic [PW-1:0] prod_nxt;

  // LO: aL*bL + (aH*bL << H)
  always_comb begin
    acc_lo = mul1_w + (mul2_w << H);
  end

  // HI: acc + (aL*bH << H) + (aH*bH << 2H); the full magnitude product is
  // below 2^(2*WIDTH), so nothing is lost in PW bits.
  always_comb begin
    sum_hi = acc + (mul1_w << H) + (mul2_w << (2 * H));
  end

  // Negating zero yields zero, so a zero operand in signed mode is safe.
  always_comb begin
    prod_nxt = neg_q ? ('0 - sum_hi) : sum_hi;
  end

  // ------------------------------------------------------------------------
  // State sequencing
  // ------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LO;
        end
      end
      LO: begin
        state_nxt = HI;
      end
      HI: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = accept ? LO : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      a_mag <= mag_1;
      b_mag <= mag_2;
      neg_q <= neg_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == LO) begin
      acc <= acc_lo;
    end
  end

  // prod only changes on the HI edge, so it is naturally held through OUT
  // and keeps its last value after the consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (state == HI) begin
      prod <= prod_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (state == HI) begin
      out_valid <= 1'b1;
    end else if ((state == OUT) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_nxn_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_nxn_seq
//
// Scoreboard bench for mult_nxn_seq. Two instances: WIDTH=8 with signed mode
// enabled, and WIDTH=16 with signed mode disabled. Drivers push the expected
// product (from an integer reference model) and the accept time into a queue;
// per-instance monitors on the falling edge compare whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_mult_nxn_seq;

  typedef struct {
    logic [31:0] p;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [7:0]  in_1, in_2;
  logic [15:0] prod;

  logic        u_in_valid, u_in_ready, u_signed_mode, u_out_valid, u_out_ready;
  logic [15:0] u_in_1, u_in_2;
  logic [31:0] u_prod;

  mult_nxn_seq #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_1(in_1), .in_2(in_2), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
  );

  mult_nxn_seq #(.WIDTH(16), .SIGNED_EN(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_1(u_in_1), .in_2(u_in_2), .signed_mode(u_signed_mode),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .prod(u_prod)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_t8     = 0;
  bit   done        = 1'b0;
  exp_t q8[$];
  exp_t q16[$];

  logic [7:0] stream_a [4] = '{8'h03, 8'h00, 8'h80, 8'hAA};
  logic [7:0] stream_b [4] = '{8'h07, 8'h00, 8'h02, 8'h55};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: interpret operands as integers, multiply, wrap to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // t is the cycle count seen on the falling edge just before the accept edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    in_1 = a; in_2 = b; signed_mode = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 64);
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout8: in_ready=0, expected 1 within 64 cycles");
    end else begin
      q8.push_back('{p: ref_mul(8, {8'd0, a}, {8'd0, b}, s), t: cyc});
      last_t8 = cyc;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; in_1 = 8'($urandom); in_2 = 8'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n = 0;
    u_in_1 = a; u_in_2 = b; u_signed_mode = s; u_in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!u_in_ready && n < 64);
    if (!u_in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout16: in_ready=0, expected 1 within 64 cycles");
    end else begin
      // signed_mode is ignored by this instance: always unsigned.
      q16.push_back('{p: ref_mul(16, a, b, 1'b0), t: cyc});
      @(posedge clk);
    end
    #1;
    u_in_valid = 1'b0; u_in_1 = 16'($urandom); u_in_2 = 16'($urandom);
    u_signed_mode = 1'($urandom);
  endtask

  // Monitor, 8-bit instance. A result must appear 2 edges after the accept
  // edge, i.e. 3 counts after the falling edge recorded at accept.
  initial begin
    logic prev_ov = 1'b0;
    logic hold    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        hold    = 1'b0;
      end else begin
        if (hold) chk("out_valid_held8", 32'(out_valid), 32'd1);
        if (out_valid && !prev_ov) begin
          if (q8.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_result8: prod=0x%0h, expected no result", prod);
          end else begin
            chk("latency8", 32'(cyc - q8[0].t), 32'd3);
          end
        end
        if (out_valid && q8.size() != 0) begin
          chk("prod8", {16'd0, prod}, q8[0].p);
          if (!out_ready) chk("busy_in_ready8", 32'(in_ready), 32'd0);
          else void'(q8.pop_front());
        end
        prev_ov = out_valid;
        hold    = out_valid && !out_ready;
      end
    end
  end

  // Monitor, 16-bit instance.
  initial begin
    logic prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (u_out_valid && !prev_ov) begin
          if (q16.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_result16: prod=0x%0h, expected no result", u_prod);
          end else begin
            chk("latency16", 32'(cyc - q16[0].t), 32'd3);
          end
        end
        if (u_out_valid && u_out_ready && q16.size() != 0) begin
          chk("prod16", u_prod, q16[0].p);
          void'(q16.pop_front());
        end
        prev_ov = u_out_valid;
      end
    end
  end

  initial begin
    int t0 = 0;
    int n  = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_1 = '0; in_2 = '0; signed_mode = 1'b0; out_ready = 1'b1;
    u_in_valid = 1'b0; u_in_1 = '0; u_in_2 = '0; u_signed_mode = 1'b0; u_out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready8",   32'(in_ready),    32'd1);
    chk("rst_out_valid8",  32'(out_valid),   32'd0);
    chk("rst_prod8",       32'(prod),        32'd0);
    chk("rst_in_ready16",  32'(u_in_ready),  32'd1);
    chk("rst_out_valid16", 32'(u_out_valid), 32'd0);
    chk("rst_prod16",      u_prod,           32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Unsigned full-scale, then back to IDLE.
    send8(8'hFF, 8'hFF, 1'b0);
    tick(4);
    chk("idle_in_ready8", 32'(in_ready), 32'd1);

    // Signed corners, including a zero operand.
    send8(8'h80, 8'h80, 1'b1);
    send8(8'h80, 8'h7F, 1'b1);
    send8(8'hFF, 8'h05, 1'b1);
    send8(8'h00, 8'h85, 1'b1);
    tick(4);

    // Back-to-back stream: accepts 3 cycles apart.
    for (int i = 0; i < 4; i++) begin
      send8(stream_a[i], stream_b[i], 1'b0);
      if (i > 0) chk("throughput8", 32'(last_t8 - t0), 32'd3);
      t0 = last_t8;
    end
    tick(4);

    // Backpressure: hold result, ignore new request, then consume+accept.
    out_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0);
    tick(3);
    in_1 = 8'h56; in_2 = 8'h78; signed_mode = 1'b0; in_valid = 1'b1;
    tick(5);
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready8", 32'(in_ready), 32'd1);
    send8(8'h56, 8'h78, 1'b0);
    tick(4);

    // Reset while in HI: immediate clear, no result afterwards.
    send8(8'h9A, 8'hBC, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid8", 32'(out_valid), 32'd0);
    chk("rst_mid_prod8",      32'(prod),      32'd0);
    chk("rst_mid_in_ready8",  32'(in_ready),  32'd1);
    q8.delete();
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_in_ready8", 32'(in_ready), 32'd1);

    // Random operands, modes, gaps and backpressure.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send8(pick8(), pick8(), 1'($urandom));
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;

    // 16-bit instance with signed mode disabled.
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    send16(16'h8000, 16'h8000, 1'b1);
    for (int i = 0; i < 20; i++) send16(16'($urandom), 16'($urandom), 1'($urandom));

    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: %0d/%0d results pending, expected 0", q8.size(), q16.size());
    end
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_nxn_seq.md
Name: mult_nxn_seq

Overview:
- Parametrised, time-multiplexed WIDTH x WIDTH multiplier built from two half-width (H = WIDTH/2) multipliers.
- Each operand is split into a low half and a high half. The four half-products are computed over two cycles and accumulated into a 2*WIDTH result.
- Adds valid/ready handshakes on input and output, output backpressure, and an optional per-transaction signed (two's complement) mode.
- Sits in the datapath wherever a narrow-area multiplier with moderate throughput is acceptable.

Parameters:
- WIDTH, 8, operand width. Must be even and at least 4; elaboration error otherwise.
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands this cycle.
- in_1  input  WIDTH  multiplicand.
- in_2  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat in_1/in_2 as two's complement; sampled with operands.
- out_valid  output  1  prod holds a finished result.
- out_ready  input  1  downstream consumes prod.
- prod  output  2*WIDTH  registered product.

Behaviour:
- Reset: clock and reset as fixed above; reset acts immediately on assertion and needs no clock.
  - State = IDLE; operand, accumulator and prod registers = 0; out_valid = 0; sign flag = 0.
  - in_ready reads 1 after reset (state IDLE).
- States: IDLE, LO, HI, OUT.
- Handshake:
  - Accept occurs on an edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==OUT && out_ready). It is combinational from state and out_ready only, never from in_valid.
  - A result is consumed on an edge where out_valid && out_ready.
- Accept edge (E0):
  - Register the operand magnitudes and the sign flag.
  - Signed mode (signed_mode && SIGNED_EN): magnitude = abs(operand), computed as a WIDTH-bit unsigned value; abs(-2^(WIDTH-1)) = 2^(WIDTH-1) fits. neg = MSB(in_1) XOR MSB(in_2).
  - Unsigned mode: magnitude = operand; neg = 0.
  - Next state LO.
- LO (edge E1):
  - Multiplier 1 computes aL*bL; multiplier 2 computes aH*bL.
  - acc <= aL*bL + ((aH*bL) << H). Next state HI.
- HI (edge E2):
  - Multiplier 1 computes aL*bH; multiplier 2 computes aH*bH.
  - sum = acc + ((aL*bH) << H) + ((aH*bH) << 2H), evaluated in 2*WIDTH bits with no overflow possible.
  - prod <= neg ? -sum : sum, in 2*WIDTH two's complement.
  - out_valid <= 1. Next state OUT.
- Multiplier inputs are muxed only by state. In IDLE/OUT they are driven with the LO selection; products are unused there.
- OUT:
  - prod and out_valid are held stable while out_ready = 0.
  - On consume with no new accept: out_valid <= 0, next state IDLE. prod keeps its last value.
  - On consume with a simultaneous accept: out_valid <= 0, new operands captured, next state LO.
- Latency: out_valid rises on the second edge after the accept edge. Sustained throughput is one result per 3 cycles with out_ready held at 1.
- in_valid while busy (LO/HI, or OUT without out_ready): ignored; in_ready = 0. The source must hold its data.
- signed_mode is sampled only at accept. Changes at other times have no effect.
- Zero operand: the result is 0 in both modes (the negated zero is 0).
- Reset mid-operation (LO/HI/OUT): everything returns to the reset values immediately; the in-flight result is discarded and never presented.

Test Plan:
- WIDTH=8, unsigned, in_1=0xFF, in_2=0xFF, out_ready=1 -> out_valid high 2 edges after accept, prod=0xFE01, then IDLE and in_ready=1.
- WIDTH=8, signed: -128 x -128 -> prod=0x4000; -128 x 127 -> prod=0xC080 (-16256); -1 x 5 -> prod=0xFFFB.
- Backpressure: result 0x12 x 0x34 = 0x03A8 with out_ready=0 for 5 cycles -> prod/out_valid stable, in_ready=0, a new in_valid is ignored. Raising out_ready with in_valid=1 -> consume and new accept on the same edge.
- Back-to-back stream of 4 operand pairs (3x7, 0x0, 0x80x0x02, 0xAAx0x55), out_ready=1 -> products 21, 0, 0x0100, 0x3872, in order, 3 cycles apart.
- Reset asserted in state HI -> out_valid=0 and prod=0 immediately, no result emitted after release, in_ready=1.
- WIDTH=16, SIGNED_EN=0 with signed_mode=1, 0xFFFF x 0xFFFF -> prod=0xFFFE0001 (unsigned), latency unchanged.
